// File: rtl/register_file_2r1w.sv
// General-purpose operand store: DEPTH x WIDTH, one write port, two registered
// write-first read ports, and a one-entry-per-cycle clear sequencer.
module register_file_2r1w #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              clear,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    CLEARING
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0]  rdata_b_q, rdata_b_d;

  // Single effective write per edge: either a user write or a clear step.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = wdata;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEARING;
          idx_d   = '0;
        end else if (we && !(ZERO_REG && waddr == '0)) begin
          wr_en = 1'b1;
        end
      end
      CLEARING: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_data = '0;
        idx_d   = idx_q + 1'b1;
        if (&idx_q) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Write-first: the read sees the value the entry holds after this edge.
  always_comb begin
    rdata_a_d = mem_q[raddr_a];
    if (wr_en && wr_addr == raddr_a) rdata_a_d = wr_data;
    if (ZERO_REG && raddr_a == '0) rdata_a_d = '0;

    rdata_b_d = mem_q[raddr_b];
    if (wr_en && wr_addr == raddr_b) rdata_b_d = wr_data;
    if (ZERO_REG && raddr_b == '0) rdata_b_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign busy    = (state_q == CLEARING);

endmodule
